// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, load-size encodings and pipeline bundle types for the writeback stage
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic [1:0]        load_size;
    logic              load_unsigned;
    logic [DATA_W-1:0] alu_result;
  } s1_t;
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two combinational reads, one synchronous write, r0 hard-wired to 0
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [32];
  always_ff @(posedge clk)
    if (we && waddr != '0) mem[waddr] <= wdata;
  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: two-stage memory/writeback pipeline with load alignment and register file.
// Define WB_BYPASS_EN to forward the pending writeback onto the read ports.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);
  s1_t s1;
  wb_t wb;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [DATA_W-1:0] ld_val, rf_rs, rf_rt;
  always_comb begin
    ld_b = 8'(mem_rdata >> {s1.alu_result[1:0], 3'b000});
    ld_h = s1.alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val = (s1.load_size == LS_BYTE) ? {{24{~s1.load_unsigned & ld_b[7]}}, ld_b} :
             (s1.load_size == LS_HALF) ? {{16{~s1.load_unsigned & ld_h[15]}}, ld_h} :
             mem_rdata;
  end
  // flush overrides stall on the stage-1 valid only; stage 2 just follows stall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      wb <= '0;
    end else begin
      if (!stall) begin
        s1 <= '{valid: in_valid, rd: rd, reg_write: reg_write, mem_to_reg: mem_to_reg,
                load_size: load_size, load_unsigned: load_unsigned, alu_result: alu_result};
        wb <= '{valid: s1.valid, we: s1.valid & s1.reg_write & (s1.rd != '0), rd: s1.rd,
                data: s1.mem_to_reg ? ld_val : s1.alu_result};
      end
      if (flush) s1.valid <= 1'b0;
    end
  assign wb_valid = wb.valid;
  assign wb_we = wb.we;
  assign wb_rd = wb.rd;
  assign wb_data = wb.data;
  regfile_2r1w u_rf (
    .clk(clk), .we(wb.we & ~stall), .waddr(wb.rd), .wdata(wb.data),
    .raddr_a(rs_addr), .raddr_b(rt_addr), .rdata_a(rf_rs), .rdata_b(rf_rt)
  );
`ifdef WB_BYPASS_EN
  assign rs_data = (wb.we && rs_addr == wb.rd) ? wb.data : rf_rs;
  assign rt_data = (wb.we && rt_addr == wb.rd) ? wb.data : rf_rt;
`else
  assign rs_data = rf_rs;
  assign rt_data = rf_rt;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic reset, in_valid, reg_write, mem_to_reg, load_unsigned, stall, flush;
  logic [31:0] alu_result, mem_rdata, rs_data, rt_data, wb_data;
  logic [4:0] rd, rs_addr, rt_addr, wb_rd;
  logic [1:0] load_size;
  logic wb_valid, wb_we;
  int checks = 0;
  int fails = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result), .rd(rd),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .load_size(load_size),
    .load_unsigned(load_unsigned), .mem_rdata(mem_rdata), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nx;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] r, input logic rw, input logic m2r,
                       input logic [1:0] ls, input logic lu);
    in_valid = 1'b1; alu_result = a; rd = r; reg_write = rw;
    mem_to_reg = m2r; load_size = ls; load_unsigned = lu;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] ls, input logic lu,
                    input logic [31:0] d, input logic [31:0] exp);
    issue(a, 5'd20, 1'b1, 1'b1, ls, lu);
    nx;
    in_valid = 1'b0;
    mem_rdata = d;
    nx;
    chk(tag, wb_data, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; alu_result = 0; rd = 0; reg_write = 0; mem_to_reg = 0;
    load_size = LS_WORD; load_unsigned = 0; mem_rdata = 0; stall = 0; flush = 0;
    rs_addr = 0; rt_addr = 0;
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    nx; nx;
    reset = 1'b0;

    // ALU result, two-edge latency then commit to r5
    issue(32'h0000_1234, 5'd5, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    nx;
    chk("alu_wb_valid", wb_valid, 1'b1);
    chk("alu_wb_we", wb_we, 1'b1);
    chk("alu_wb_rd", wb_rd, 5'd5);
    chk("alu_wb_data", wb_data, 32'h0000_1234);
    rs_addr = 5'd5;
    nx;
    chk("alu_r5", rs_data, 32'h0000_1234);
    chk("alu_wb_drop", wb_valid, 1'b0);

    // back-to-back: one writeback per cycle
    issue(32'h11, 5'd9, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    issue(32'h22, 5'd10, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    chk("b2b_a_data", wb_data, 32'h11);
    chk("b2b_a_rd", wb_rd, 5'd9);
    in_valid = 1'b0;
    rs_addr = 5'd9;
    nx;
    chk("b2b_b_valid", wb_valid, 1'b1);
    chk("b2b_b_data", wb_data, 32'h22);
    chk("b2b_r9", rs_data, 32'h11);
    rt_addr = 5'd10;
    nx;
    chk("b2b_r10", rt_data, 32'h22);

    ld("byte3_s", 32'h103, LS_BYTE, 1'b0, 32'h80FF_7F01, 32'hFFFF_FF80);
    ld("byte3_u", 32'h103, LS_BYTE, 1'b1, 32'h80FF_7F01, 32'h0000_0080);
    ld("byte1_s", 32'h101, LS_BYTE, 1'b0, 32'h80FF_7F01, 32'h0000_007F);
    ld("byte2_s", 32'h102, LS_BYTE, 1'b0, 32'h80FF_7F01, 32'hFFFF_FFFF);
    ld("half2_s", 32'h102, LS_HALF, 1'b0, 32'h8001_7FFE, 32'hFFFF_8001);
    ld("half0_s", 32'h100, LS_HALF, 1'b0, 32'h8001_7FFE, 32'h0000_7FFE);
    ld("half3_u", 32'h103, LS_HALF, 1'b1, 32'h8001_7FFE, 32'h0000_8001);
    ld("word", 32'h100, LS_WORD, 1'b0, 32'h8001_7FFE, 32'h8001_7FFE);
    ld("rsvd_word", 32'h101, 2'b11, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    chk("ld_wb_rd", wb_rd, 5'd20);

    // write to r0 is suppressed
    issue(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    nx;
    chk("r0_wb_valid", wb_valid, 1'b1);
    chk("r0_wb_we", wb_we, 1'b0);
    chk("r0_wb_data", wb_data, 32'hDEAD_BEEF);
    rs_addr = 5'd0;
    nx;
    chk("r0_read", rs_data, 32'h0);

    // load held in stage 1 across a 3-cycle stall
    issue(32'h101, 5'd9, 1'b1, 1'b1, LS_BYTE, 1'b1);
    nx;
    in_valid = 1'b0;
    mem_rdata = 32'h0000_AB00;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nx;
      chk("stall_s1_frozen", wb_valid, 1'b0);
    end
    stall = 1'b0;
    nx;
    chk("stall_rel_valid", wb_valid, 1'b1);
    chk("stall_rel_data", wb_data, 32'h0000_00AB);
    chk("stall_rel_we", wb_we, 1'b1);
    stall = 1'b1;
    rs_addr = 5'd9;
    nx;
    chk("stall_wb_we_held", wb_we, 1'b1);
    chk("stall_wb_data_held", wb_data, 32'h0000_00AB);
    chk("stall_no_commit1", rs_data, 32'h11);
    nx;
    chk("stall_no_commit2", rs_data, 32'h11);
    stall = 1'b0;
    nx;
    chk("stall_commit", rs_data, 32'h0000_00AB);
    chk("stall_single_wb", wb_valid, 1'b0);

    // flush wins over stall in stage 1
    issue(32'h77, 5'd12, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    stall = 1'b1;
    flush = 1'b1;
    nx;
    stall = 1'b0;
    flush = 1'b0;
    nx;
    chk("flush_stall_valid", wb_valid, 1'b0);
    chk("flush_stall_we", wb_we, 1'b0);
    nx;
    chk("flush_stall_valid2", wb_valid, 1'b0);

    // flush does not touch stage 2 or its pending write
    issue(32'h66, 5'd11, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    nx;
    flush = 1'b1;
    rs_addr = 5'd11;
    nx;
    flush = 1'b0;
    chk("flush_s2_commit", rs_data, 32'h66);

    // bypass or stored value while r7 write is pending
    issue(32'h33, 5'd7, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    nx;
    nx;
    issue(32'h55, 5'd7, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    rs_addr = 5'd7;
    rt_addr = 5'd7;
    nx;
    chk("byp_wb_we", wb_we, 1'b1);
`ifdef WB_BYPASS_EN
    chk("byp_rs", rs_data, 32'h55);
    chk("byp_rt", rt_data, 32'h55);
`else
    chk("nobyp_rs", rs_data, 32'h33);
    chk("nobyp_rt", rt_data, 32'h33);
`endif
    nx;
    chk("byp_after", rs_data, 32'h55);

    // async reset kills a pending write
    issue(32'h99, 5'd9, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    nx;
    chk("rst_mid_pending", wb_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", wb_we, 1'b0);
    chk("rst_mid_valid", wb_valid, 1'b0);
    chk("rst_mid_data", wb_data, 32'h0);
    issue(32'h98, 5'd9, 1'b1, 1'b0, LS_WORD, 1'b0);
    nx;
    in_valid = 1'b0;
    nx;
    reset = 1'b0;
    rs_addr = 5'd9;
    nx;
    chk("rst_mid_r9", rs_data, 32'h0000_00AB);
    chk("rst_mid_drop", wb_valid, 1'b0);
    nx;
    chk("rst_mid_drop2", wb_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous, active-high.
REQ-002 SHALL have in_valid in 1, an instruction leaves the memory stage this cycle.
REQ-003 SHALL have alu_result in 32, ALU result or load address; rd in 5, destination register; reg_write in 1; mem_to_reg in 1, load instruction.
REQ-004 SHALL have load_size in 2 (00 word, 01 half, 10 byte, 11 reserved as word); load_unsigned in 1.
REQ-005 SHALL have mem_rdata in 32, registered memory read word, valid the cycle after in_valid.
REQ-006 SHALL have stall in 1, hold all stage state; flush in 1, kill the stage-1 instruction.
REQ-007 SHALL have wb_valid out 1, wb_we out 1, wb_rd out 5, wb_data out 32: registered writeback bundle.
REQ-008 SHALL have rs_addr in 5, rt_addr in 5, rs_data out 32, rt_data out 32: combinational register-file read ports.

Function
REQ-009 Stage 1 SHALL capture {in_valid, rd, reg_write, mem_to_reg, load_size, load_unsigned, alu_result[1:0], alu_result} on the clk edge when stall=0, aligning control with mem_rdata.
REQ-010 Stage 2 SHALL register wb_* from stage 1 plus mem_rdata on the next unstalled edge: in_valid at edge k gives wb_valid after edge k+1, a latency of 2 edges.
REQ-011 wb_data SHALL be alu_result when mem_to_reg=0, else the aligned load value.
REQ-012 Load alignment SHALL be little-endian. Byte: mem_rdata[8*off+7:8*off] with off=alu_result[1:0]. Half: mem_rdata[16*off[1]+15:16*off[1]], with off[0] ignored. Word: the full word.
REQ-013 Loads SHALL sign-extend when load_unsigned=0 and zero-extend when load_unsigned=1.
REQ-014 wb_we SHALL equal wb_valid AND reg_write AND (wb_rd != 0).
REQ-015 The register file (32x32) SHALL be written with wb_data at wb_rd on the edge after wb_we is asserted, unless stall=1.
REQ-016 Register r0 SHALL always read 0, and writes to r0 SHALL be discarded.
REQ-017 stall=1 SHALL hold stage 1, stage 2 and the register file unchanged; wb_we SHALL remain visible but SHALL NOT commit until stall=0.
REQ-018 flush=1 SHALL clear the stage-1 valid on the edge; flush SHALL have priority over stall for stage 1 only.
REQ-019 flush SHALL NOT affect stage 2 or a pending register-file write.
REQ-020 Back-to-back in_valid every cycle SHALL sustain one writeback per cycle with no bubbles.

Reset
REQ-021 reset=1 SHALL asynchronously clear both stage valids, wb_valid=0, wb_we=0, wb_rd=0 and wb_data=0.
REQ-022 reset SHALL NOT be required to clear the register-file contents; r0 SHALL still read 0.
REQ-023 reset asserted mid-operation SHALL drop all in-flight instructions, and no register-file write SHALL occur while reset=1.

Configuration
REQ-024 With WB_BYPASS_EN defined, rs_data/rt_data SHALL return wb_data when wb_we=1 and the read address equals wb_rd (write-first bypass).
REQ-025 Without WB_BYPASS_EN, read ports SHALL return the stored register-file contents only.

Structure
REQ-026 Package mips_pkg SHALL hold DATA_W=32, REG_AW=5, the load_size encoding constants (LS_WORD, LS_HALF, LS_BYTE) and the writeback bundle typedef.
REQ-027 The register file SHALL be a sub-module regfile_2r1w with 2 combinational read ports and 1 synchronous write port, r0 hard-wired to 0.
REQ-028 Load alignment and extension SHALL be combinational logic inside mem_wb_stage.

Verification
REQ-029 ALU op: alu_result=0x0000_1234, rd=5, reg_write=1, mem_to_reg=0 -> two edges later wb_data=0x1234 and wb_we=1; next edge reg5=0x1234.
REQ-030 Signed byte load: mem_rdata=0x80FF_7F01, off=3, byte -> wb_data=0xFFFF_FF80. Unsigned byte, same data -> 0x0000_0080.
REQ-031 Half load: mem_rdata=0x8001_7FFE, off=2, signed -> 0xFFFF_8001; off=0 signed -> 0x0000_7FFE.
REQ-032 Write to r0 with value 0xDEAD_BEEF -> wb_we=0 and rs_addr=0 reads 0.
REQ-033 stall held 3 cycles with a load in stage 1 -> outputs frozen, correct single writeback after release. flush with stall in the same cycle -> stage-1 instruction never writes back.
REQ-034 With WB_BYPASS_EN defined, rs_addr=7 while wb_we=1, wb_rd=7, wb_data=0x55 -> rs_data=0x55 the same cycle. Without the macro, rs_data returns the old reg7 value.
